ss_modport: RTL and testbench
=============================

Name: ss_modport

Overview:
- Slave-side data stack for the eForth1 core, serving the ss_io stack bus (op, vi in; sp, sp_1, s0, tos out).
- Keeps the top-of-stack (TOS) in a register and the rest of the stack in a DEPTH-entry circular array.
- Exposes the entry below TOS (s0) combinationally so the master can pop in the same cycle.
- Sits beside the ALU/sequencer, which drives op/vi every cycle.

Parameters:
- DEPTH, 64: number of array entries; power of two.
- DSZ, 32: data width.
- SSZ, $clog2(DEPTH) (derived, not overridable): stack-pointer width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  op strobe; no state change when low.
- op  input  2  sop_e: SS_LOAD=0, SS_PUSH=1, SS_POP=2, SS_PICK=3.
- vi  input  DSZ  push/load value, or pick index.
- tos  output  DSZ  top of stack (registered).
- s0  output  DSZ  second element, mem[sp] (combinational read).
- sp  output  SSZ  array pointer (registered).
- sp_1  output  SSZ  sp+DEPTH-1 modulo DEPTH, i.e. sp-1 (combinational).

Behaviour:
- Interface fixed: one clock (clk); reset asynchronous, active-low (rst_n).
- Reset, immediate on rst_n low, independent of clk:
  - tos = all ones (-1).
  - sp = 0.
  - Array contents are not reset; s0 is undefined until written.
- Every rising clk edge with en=1 executes op. All results are visible one cycle later.
- SS_LOAD: tos<=vi; sp and array unchanged.
- SS_PUSH: mem[sp+1]<=tos; sp<=sp+1; tos<=vi. s0 then shows the old tos.
- SS_POP: tos<=mem[sp], i.e. s0 before the edge; sp<=sp-1.
  - The master takes the popped value from s0 combinationally in the same cycle.
- SS_PICK: tos<=mem[(sp - vi[SSZ-1:0]) mod DEPTH]; sp and array unchanged.
  - vi=0 copies s0. vi=1 copies the entry below s0.
- en=0: all registers and the array hold.
- Pointer arithmetic is modulo DEPTH:
  - PUSH at sp=DEPTH-1 wraps sp to 0 and overwrites the oldest entry.
  - POP at sp=0 wraps sp to DEPTH-1.
  - No error is raised without the optional feature.
- sp_1 always equals (sp+DEPTH-1) mod DEPTH; at sp=0, sp_1=DEPTH-1.
- Array: one write port, written only by PUSH. Two combinational read ports: s0 and pick address.
- Reset asserted mid-operation aborts any op in progress; the first edge after rst_n rises executes normally.

Optional Feature:
- Macro SS_GUARD_EN.
- When defined, adds output err (1 bit) and an internal depth counter (0..DEPTH):
  - PUSH increments depth; POP decrements it.
  - PUSH at depth=DEPTH or POP at depth=0 is suppressed (no state change) and sets err.
  - PICK with vi >= depth is suppressed and sets err.
  - err is sticky until reset; reset clears err and depth.
- When undefined, there is no err port or depth counter, and wrap-around is silent as specified above.

Decomposition:
- Shared package eforth1_pkg holds:
  - the sop_e enum.
  - DSZ and DEPTH defaults.
  - NEG1 = DEPTH-1 constant.
- One sub-module is natural: ss_ram, a DEPTH x DSZ array with one synchronous write and two asynchronous reads, instantiated once.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> tos=32'hFFFF_FFFF, sp=0, sp_1=63 immediately, without waiting for a clk edge.
- Push sequence: PUSH 0x11, 0x22, 0x33 -> tos=0x33, sp=3, s0=0x22, sp_1=2.
- Pop: from that state, one POP -> tos=0x22, s0=0x11, sp=2; s0 read 0x22 in the POP cycle.
- Load/hold: LOAD 0xABCD -> tos=0xABCD, sp unchanged; then en=0 with op=PUSH for 3 cycles -> nothing changes.
- Pick: stack (bottom->top) 0x11, 0x22, 0x33, tos=0x44; PICK vi=2 -> tos=0x11, sp unchanged.
- Wrap: 64 PUSHes after reset -> sp=0 (wrapped), sp_1=63. With SS_GUARD_EN, the 65th PUSH -> err=1 and sp held.

Source files
------------

// File: rtl/eforth1_pkg.sv
// Shared types and defaults for the eForth1 stack units.
// Holds the stack-op encoding and the default geometry of the data stack.
package eforth1_pkg;

  localparam int DSZ_DEF   = 32;
  localparam int DEPTH_DEF = 64;
  localparam int NEG1      = DEPTH_DEF - 1;

  typedef enum logic [1:0] {
    SS_LOAD = 2'd0,
    SS_PUSH = 2'd1,
    SS_POP  = 2'd2,
    SS_PICK = 2'd3
  } sop_e;

endpackage

// File: rtl/ss_ram.sv
// DEPTH x DSZ register array: one synchronous write port, two asynchronous reads.
// Contents are deliberately not reset so the array can map onto distributed RAM.
module ss_ram #(
  parameter int DEPTH = 64,
  parameter int DSZ   = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           we,
  input  logic [AW-1:0]  wa,
  input  logic [DSZ-1:0] wd,
  input  logic [AW-1:0]  ra0,
  input  logic [AW-1:0]  ra1,
  output logic [DSZ-1:0] rd0,
  output logic [DSZ-1:0] rd1
);

  logic [DSZ-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];

endmodule

// File: rtl/ss_modport.sv
// eForth1 data stack slave: registered TOS plus a circular array holding the rest.
// Define SS_GUARD_EN to add a depth counter and a sticky overflow/underflow err output.
module ss_modport
  import eforth1_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int DSZ   = DSZ_DEF,
  localparam int SSZ   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  sop_e           op,
  input  logic [DSZ-1:0] vi,
  output logic [DSZ-1:0] tos,
  output logic [DSZ-1:0] s0,
  output logic [SSZ-1:0] sp,
  output logic [SSZ-1:0] sp_1
`ifdef SS_GUARD_EN
  ,
  output logic           err
`endif
);

  logic [SSZ-1:0] sp_inc;
  logic [SSZ-1:0] pick_addr;
  logic [DSZ-1:0] pick_data;
  logic           allow;
  logic           push_we;

  assign sp_inc    = sp + SSZ'(1);
  assign sp_1      = sp - SSZ'(1);
  assign pick_addr = sp - vi[SSZ-1:0];
  assign push_we   = en && allow && (op == SS_PUSH);

  ss_ram #(
    .DEPTH (DEPTH),
    .DSZ   (DSZ),
    .AW    (SSZ)
  ) u_ram (
    .clk (clk),
    .we  (push_we),
    .wa  (sp_inc),
    .wd  (tos),
    .ra0 (sp),
    .ra1 (pick_addr),
    .rd0 (s0),
    .rd1 (pick_data)
  );

`ifdef SS_GUARD_EN
  logic [SSZ:0] depth;

  // Ops that would over/underflow the tracked depth are dropped entirely.
  always_comb begin
    allow = 1'b1;
    case (op)
      SS_PUSH: allow = (depth != (SSZ+1)'(DEPTH));
      SS_POP:  allow = (depth != '0);
      SS_PICK: allow = (vi < DSZ'(depth));
      default: allow = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth <= '0;
      err   <= 1'b0;
    end else if (en) begin
      if (!allow) err <= 1'b1;
      else if (op == SS_PUSH) depth <= depth + 1'b1;
      else if (op == SS_POP) depth <= depth - 1'b1;
    end
  end
`else
  logic unused_vi;

  assign allow     = 1'b1;
  assign unused_vi = ^vi[DSZ-1:SSZ];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tos <= '1;
      sp  <= '0;
    end else if (en && allow) begin
      case (op)
        SS_LOAD: tos <= vi;
        SS_PUSH: begin
          tos <= vi;
          sp  <= sp_inc;
        end
        SS_POP: begin
          tos <= s0;
          sp  <= sp_1;
        end
        SS_PICK: tos <= pick_data;
        default: tos <= tos;
      endcase
    end
  end

endmodule

// File: tb/tb_ss_modport.sv
// Self-checking bench for ss_modport: directed scenarios then randomized ops vs a stack model.
// Compile with SS_GUARD_EN defined to also exercise the err output.
module tb_ss_modport;
  import eforth1_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        en;
  sop_e        op;
  logic [31:0] vi;
  logic [31:0] tos;
  logic [31:0] s0;
  logic [5:0]  sp;
  logic [5:0]  sp_1;
`ifdef SS_GUARD_EN
  logic        err;
`endif

  ss_modport #(.DEPTH(64), .DSZ(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .op    (op),
    .vi    (vi),
    .tos   (tos),
    .s0    (s0),
    .sp    (sp),
    .sp_1  (sp_1)
`ifdef SS_GUARD_EN
    ,
    .err   (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model: the stack as a plain array with modular indices.
  logic [31:0] m_mem [64];
  bit          m_val [64];
  int          m_sp;
  logic [31:0] m_tos;
  bit          m_tos_ok;
  int          m_depth;
  bit          m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_sp     = 0;
    m_tos    = 32'hFFFF_FFFF;
    m_tos_ok = 1'b1;
    m_depth  = 0;
    m_err    = 1'b0;
  endtask

  task automatic model_step(input logic e, input sop_e o, input logic [31:0] v);
    int n;
`ifdef SS_GUARD_EN
    bit ok;
`endif
    if (!e) return;
`ifdef SS_GUARD_EN
    case (o)
      SS_PUSH: ok = (m_depth < 64);
      SS_POP:  ok = (m_depth > 0);
      SS_PICK: ok = (v < 32'(m_depth));
      default: ok = 1'b1;
    endcase
    if (!ok) begin
      m_err = 1'b1;
      return;
    end
`endif
    case (o)
      SS_LOAD: begin
        m_tos    = v;
        m_tos_ok = 1'b1;
      end
      SS_PUSH: begin
        n        = (m_sp + 1) % 64;
        m_mem[n] = m_tos;
        m_val[n] = m_tos_ok;
        m_sp     = n;
        m_tos    = v;
        m_tos_ok = 1'b1;
        m_depth++;
      end
      SS_POP: begin
        m_tos    = m_mem[m_sp];
        m_tos_ok = m_val[m_sp];
        m_sp     = (m_sp + 63) % 64;
        m_depth--;
      end
      default: begin
        n        = (m_sp - int'(v % 64) + 64) % 64;
        m_tos    = m_mem[n];
        m_tos_ok = m_val[n];
      end
    endcase
  endtask

  task automatic check_output();
    if (m_tos_ok) check("tos", tos, m_tos);
    check("sp", 32'(sp), 32'(m_sp));
    check("sp_1", 32'(sp_1), 32'((m_sp + 63) % 64));
    if (m_val[m_sp]) check("s0", s0, m_mem[m_sp]);
`ifdef SS_GUARD_EN
    check("err", 32'(err), 32'(m_err));
`endif
  endtask

  // Called at a falling edge; inputs settle before the next rising edge.
  task automatic apply_stimulus(input logic e, input sop_e o, input logic [31:0] v);
    en = e;
    op = o;
    vi = v;
    @(posedge clk);
    model_step(e, o, v);
    #1 check_output();
    @(negedge clk);
  endtask

  task automatic do_reset();
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_tos", tos, 32'hFFFF_FFFF);
    check("rst_sp", 32'(sp), 32'd0);
    check("rst_sp_1", 32'(sp_1), 32'(NEG1));
`ifdef SS_GUARD_EN
    check("rst_err", 32'(err), 32'd0);
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    op    = SS_LOAD;
    vi    = '0;
    model_reset();
    @(negedge clk);

    do_reset();
    apply_stimulus(1'b1, SS_PUSH, 32'h11);
    apply_stimulus(1'b1, SS_PUSH, 32'h22);
    apply_stimulus(1'b1, SS_PUSH, 32'h33);
    check("push_tos", tos, 32'h33);
    check("push_sp", 32'(sp), 32'd3);
    check("push_s0", s0, 32'h22);
    check("push_sp_1", 32'(sp_1), 32'd2);

    apply_stimulus(1'b1, SS_POP, 32'h0);
    check("pop_tos", tos, 32'h22);
    check("pop_s0", s0, 32'h11);
    check("pop_sp", 32'(sp), 32'd2);

    apply_stimulus(1'b1, SS_LOAD, 32'hABCD);
    check("load_tos", tos, 32'hABCD);
    check("load_sp", 32'(sp), 32'd2);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, SS_PUSH, $urandom);
    check("hold_tos", tos, 32'hABCD);
    check("hold_sp", 32'(sp), 32'd2);

    do_reset();
    apply_stimulus(1'b1, SS_PUSH, 32'h11);
    apply_stimulus(1'b1, SS_PUSH, 32'h22);
    apply_stimulus(1'b1, SS_PUSH, 32'h33);
    apply_stimulus(1'b1, SS_PUSH, 32'h44);
    apply_stimulus(1'b1, SS_PICK, 32'd2);
    check("pick_tos", tos, 32'h11);
    check("pick_sp", 32'(sp), 32'd4);
    apply_stimulus(1'b1, SS_PICK, 32'd0);
    check("pick0_tos", tos, 32'h33);

    do_reset();
    for (int i = 0; i < 64; i++) apply_stimulus(1'b1, SS_PUSH, $urandom);
    check("wrap_sp", 32'(sp), 32'd0);
    check("wrap_sp_1", 32'(sp_1), 32'd63);
    apply_stimulus(1'b1, SS_PUSH, 32'h5A5A);
`ifdef SS_GUARD_EN
    check("guard_err", 32'(err), 32'd1);
    check("guard_sp", 32'(sp), 32'd0);
`else
    check("wrap65_sp", 32'(sp), 32'd1);
    check("wrap65_tos", tos, 32'h5A5A);
`endif

    for (int i = 0; i < 400; i++) begin
      logic        e;
      sop_e        o;
      logic [31:0] v;
      if (i == 200) do_reset();
      e = ($urandom_range(0, 9) != 0);
      o = sop_e'($urandom_range(0, 3));
      v = (o == SS_PICK) ? 32'($urandom_range(0, 70)) : $urandom;
      apply_stimulus(e, o, v);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
